// File: rtl/crown_anim_ctrl.sv
// Winner-crown animation sequencer: drop, single bounce, hold, done; advances once per frame_tick.
// Optional CROWN_BLINK_EN: crown blinks during HOLD every BLINK_FRAMES frame ticks.
module crown_anim_ctrl #(
    parameter int unsigned X_BASE       = 40,
    parameter int unsigned X_PITCH      = 160,
    parameter int unsigned START_Y      = 0,
    parameter int unsigned Y_TARGET     = 200,
    parameter int unsigned DROP_STEP    = 8,
    parameter int unsigned BOUNCE_H     = 4,
    parameter int unsigned HOLD_FRAMES  = 60,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [1:0] winner,
    input  logic       abort,
    output logic [9:0] x_pin,
    output logic [9:0] y_pin,
    output logic       visible,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {S_IDLE, S_DROP, S_BOUNCE, S_HOLD, S_DONE} state_t;

    localparam int unsigned BW = $clog2(2 * BOUNCE_H + 1);
    localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
    localparam int unsigned KW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [9:0]    C_XB   = 10'(X_BASE);
    localparam logic [9:0]    C_XP   = 10'(X_PITCH);
    localparam logic [9:0]    C_SY   = 10'(START_Y);
    localparam logic [9:0]    C_YT   = 10'(Y_TARGET);
    localparam logic [9:0]    C_STEP = 10'(DROP_STEP);
    localparam logic [BW-1:0] C_BH   = BW'(BOUNCE_H);
    localparam logic [BW-1:0] C_B2   = BW'(2 * BOUNCE_H);
    localparam logic [HW-1:0] C_HOLD = HW'(HOLD_FRAMES);
    localparam logic [KW-1:0] C_BLK  = KW'(BLINK_FRAMES - 1);

    state_t        r_state, w_state_nx;
    logic [9:0]    r_x, w_x_nx;
    logic [9:0]    r_y, w_y_nx;
    logic          r_vis, w_vis_nx;
    logic          r_busy, r_done;
    logic [BW-1:0] r_bcnt, w_bcnt_nx, w_bnext, w_bdist;
    logic [HW-1:0] r_hcnt, w_hcnt_nx, w_hnext;
    logic [KW-1:0] r_kcnt, w_kcnt_nx;
    logic [10:0]   w_ysum;

    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_vis_nx   = r_vis;
        w_bcnt_nx  = r_bcnt;
        w_hcnt_nx  = r_hcnt;
        w_kcnt_nx  = r_kcnt;
        w_bnext    = r_bcnt + 1'b1;
        w_hnext    = r_hcnt + 1'b1;
        w_bdist    = (w_bnext <= C_BH) ? w_bnext : (C_B2 - w_bnext);
        w_ysum     = {1'b0, r_y} + {1'b0, C_STEP};

        if (abort) begin
            w_state_nx = S_IDLE;
            w_x_nx     = '0;
            w_y_nx     = '0;
            w_vis_nx   = 1'b0;
            w_bcnt_nx  = '0;
            w_hcnt_nx  = '0;
            w_kcnt_nx  = '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nx = S_DROP;
                        w_x_nx     = C_XB + 10'(winner) * C_XP;
                        w_y_nx     = C_SY;
                        w_vis_nx   = 1'b1;
                        w_bcnt_nx  = '0;
                        w_hcnt_nx  = '0;
                        w_kcnt_nx  = '0;
                    end
                end
                S_DROP: begin
                    if (frame_tick) begin
                        // Saturate on the target row so the drop never overshoots.
                        if (w_ysum >= {1'b0, C_YT}) begin
                            w_y_nx     = C_YT;
                            w_bcnt_nx  = '0;
                            w_state_nx = S_BOUNCE;
                        end else begin
                            w_y_nx = w_ysum[9:0];
                        end
                    end
                end
                S_BOUNCE: begin
                    if (frame_tick) begin
                        w_bcnt_nx = w_bnext;
                        w_y_nx    = C_YT - 10'(w_bdist);
                        if (w_bnext == C_B2) begin
                            w_state_nx = S_HOLD;
                            w_hcnt_nx  = '0;
                            w_kcnt_nx  = '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (frame_tick) begin
                        w_hcnt_nx = w_hnext;
                        w_kcnt_nx = (r_kcnt == C_BLK) ? '0 : r_kcnt + 1'b1;
`ifdef CROWN_BLINK_EN
                        if (r_kcnt == C_BLK) begin
                            w_vis_nx = ~r_vis;
                        end
`endif
                        if (w_hnext == C_HOLD) begin
                            w_state_nx = S_DONE;
                            w_vis_nx   = 1'b1;
                        end
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_vis   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcnt  <= '0;
            r_hcnt  <= '0;
            r_kcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_vis   <= w_vis_nx;
            r_busy  <= (w_state_nx == S_DROP) || (w_state_nx == S_BOUNCE) || (w_state_nx == S_HOLD);
            r_done  <= (w_state_nx == S_DONE);
            r_bcnt  <= w_bcnt_nx;
            r_hcnt  <= w_hcnt_nx;
            r_kcnt  <= w_kcnt_nx;
        end
    end

    assign x_pin   = r_x;
    assign y_pin   = r_y;
    assign visible = r_vis;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
